hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised forwarding and hazard controller for the 5-stage pipeline, replacing the single-path EX/MEM forwarding logic. It selects EX operand sources from both the EX/MEM and MEM/WB stages. It also detects load-use hazards in ID and runs a small stall sequencer that holds IF/ID and injects bubbles into ID/EX for a configurable number of cycles. It sits beside the ID/EX register and drives the EX operand muxes, PC/IF-ID write enables and the ID/EX flush.

## Interface
- REG_AW, 5, register address width
- LOAD_STALL, 1, stall cycles per load-use hazard (legal 1..7)

- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- ID_rs, ID_rt  in  REG_AW  source registers of the instruction in ID
- ID_useRs, ID_useRt  in  1  ID instruction actually reads rs / rt
- ID_EX_rs, ID_EX_rt  in  REG_AW  source registers of the instruction in EX
- ID_EX_memRead  in  1  instruction in EX is a load
- ID_EX_rd  in  REG_AW  destination of the instruction in EX
- EX_M_regWrite  in  1  EX/MEM instruction writes the register file
- EX_M_rd  in  REG_AW  EX/MEM destination
- M_WB_regWrite  in  1  MEM/WB instruction writes the register file
- M_WB_rd  in  REG_AW  MEM/WB destination
- flush  in  1  taken branch or jump; kills the ID instruction
- forwardA, forwardB  out  2  operand source: 00 register file, 01 EX/MEM, 10 MEM/WB (11 never driven)
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load a NOP into ID/EX
- busy  out  1  sequencer is in STALL state

## Operation
- Forwarding is combinational:
  - forwardA = 01 if EX_M_regWrite, EX_M_rd != 0 and EX_M_rd == ID_EX_rs.
  - Otherwise forwardA = 10 if M_WB_regWrite, M_WB_rd != 0 and M_WB_rd == ID_EX_rs.
  - Otherwise forwardA = 00.
  - forwardB is identical, using ID_EX_rt.
- EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- Hazard detect: hit = ID_EX_memRead && ID_EX_rd != 0 && ((ID_useRs && ID_EX_rd == ID_rs) || (ID_useRt && ID_EX_rd == ID_rt)).
- Sequencer states: IDLE and STALL, with a 3-bit counter cnt.
  - IDLE, hit, !flush: stall = bubble = 1 this cycle. If LOAD_STALL > 1, go to STALL with cnt = LOAD_STALL-2; else remain in IDLE.
  - STALL: stall = bubble = busy = 1. If cnt == 0, go to IDLE; else cnt decrements.
  - flush in any state: go to IDLE next cycle. stall = bubble = 0 in the flush cycle; the flush logic owns the pipeline then.
  - hit while in STALL: ignored; the stall is already in progress.
- While rst is high: stall = bubble = busy = 0 and forwardA = forwardB = 00. State becomes IDLE and cnt becomes 0 at the clock edge.

## Timing
- Forward outputs: zero latency, valid in the same cycle as their inputs.
- stall/bubble in the detect cycle: combinational from hit (Mealy).
- Subsequent stall cycles come from registered state.
- Total stall length per hazard is exactly LOAD_STALL cycles. The ID instruction re-evaluates on the cycle after the last stall cycle.
- Reset mid-STALL: outputs drop in the reset cycle, IDLE is reached at the next edge, and no residual stall follows.
- A hit and flush in the same cycle: flush wins, with no stall and no state change other than IDLE.
- Back-to-back loads feeding each other: each hit starts a fresh sequence after the previous one returns to IDLE.

## Configuration
- HAZARD_WB_FWD_EN defined: MEM/WB forwarding path active as above.
- HAZARD_WB_FWD_EN undefined: code 10 is never generated, so forwardA/B ∈ {00, 01}. The register file's write-before-read handles the WB distance. Hazard detection and the sequencer are unchanged.

## Test plan
- EX_M_regWrite=1, EX_M_rd=8, M_WB_regWrite=1, M_WB_rd=8, ID_EX_rs=8 -> forwardA=01 (priority). Then drop EX_M_regWrite -> forwardA=10 (00 with macro off).
- EX_M_rd=0, EX_M_regWrite=1, ID_EX_rs=0, ID_EX_rt=0 -> forwardA=forwardB=00.
- LOAD_STALL=1: ID_EX_memRead=1, ID_EX_rd=9, ID_rt=9, ID_useRt=1 -> stall=bubble=1 for exactly 1 cycle, busy stays 0. The same hit with ID_useRt=0 -> no stall.
- LOAD_STALL=3: single hit pulse -> stall=bubble=1 for 3 consecutive cycles, busy=1 on cycles 2–3, then all 0.
- LOAD_STALL=3: hit, then flush=1 on stall cycle 2 -> stall=0 that cycle, busy=0 next cycle. A separate case with hit and flush in the same cycle -> stall=0 throughout.
- LOAD_STALL=4: rst=1 during stall cycle 2 -> outputs 0 immediately, busy=0 after the edge, and no stall once rst is released.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: EX operand forwarding select plus load-use stall sequencer
// for the 5-stage pipeline.
//
// Build option: define HAZARD_WB_FWD_EN to enable the MEM/WB forwarding
// path (forward code 10). Without it only EX/MEM forwarding (01) is
// produced and the register file's write-before-read covers the WB distance.
//
// Handshake/timing contract: there is no valid/ready pair here. Forward
// selects are purely combinational from the current stage fields. stall and
// bubble are asserted together; in the detect cycle they follow hit
// combinationally, afterwards they come from the registered sequencer state.
// flush and rst both force stall/bubble low in the cycle they are high.
// busy mirrors the sequencer's STALL state and doubles as its debug view.
module hazard_unit #(
   parameter int REG_AW     = 5,
   parameter int LOAD_STALL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ID_rs,
   input  logic [REG_AW-1:0] ID_rt,
   input  logic              ID_useRs,
   input  logic              ID_useRt,
   input  logic [REG_AW-1:0] ID_EX_rs,
   input  logic [REG_AW-1:0] ID_EX_rt,
   input  logic              ID_EX_memRead,
   input  logic [REG_AW-1:0] ID_EX_rd,
   input  logic              EX_M_regWrite,
   input  logic [REG_AW-1:0] EX_M_rd,
   input  logic              M_WB_regWrite,
   input  logic [REG_AW-1:0] M_WB_rd,
   input  logic              flush,
   output logic [1:0]        forwardA,
   output logic [1:0]        forwardB,
   output logic              stall,
   output logic              bubble,
   output logic              busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   // Cycles still to stall after the first STALL cycle: the detect cycle is
   // stall cycle 1, so STALL is entered with LOAD_STALL-2 remaining.
   localparam bit         MULTI    = (LOAD_STALL > 1);
   localparam logic [2:0] CNT_INIT = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 2) : 3'd0;

   state_t     state;
   logic [2:0] cnt;
   logic       hit;

   logic ex_valid;
   logic ex_hit_a;
   logic ex_hit_b;

   assign ex_valid = EX_M_regWrite && (EX_M_rd != '0);
   assign ex_hit_a = ex_valid && (EX_M_rd == ID_EX_rs);
   assign ex_hit_b = ex_valid && (EX_M_rd == ID_EX_rt);

`ifdef HAZARD_WB_FWD_EN
   logic wb_valid;
   logic wb_hit_a;
   logic wb_hit_b;

   assign wb_valid = M_WB_regWrite && (M_WB_rd != '0);
   assign wb_hit_a = wb_valid && (M_WB_rd == ID_EX_rs);
   assign wb_hit_b = wb_valid && (M_WB_rd == ID_EX_rt);
`else
   // MEM/WB fields are not consulted in this build.
   logic unused_wb;
   assign unused_wb = M_WB_regWrite | (|M_WB_rd);
`endif

   // Operand source selection; EX/MEM is checked last so it overrides MEM/WB.
   always_comb begin
      forwardA = 2'b00;
      forwardB = 2'b00;
      if (!rst) begin
`ifdef HAZARD_WB_FWD_EN
         if (wb_hit_a) forwardA = 2'b10;
         if (wb_hit_b) forwardB = 2'b10;
`endif
         if (ex_hit_a) forwardA = 2'b01;
         if (ex_hit_b) forwardB = 2'b01;
      end
   end

   // Load-use detect: the load in EX writes a register the ID instruction reads.
   assign hit = ID_EX_memRead && (ID_EX_rd != '0) &&
                ((ID_useRs && (ID_EX_rd == ID_rs)) ||
                 (ID_useRt && (ID_EX_rd == ID_rt)));

   // Stall sequencer: counts out the remaining stall cycles after a hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (hit && MULTI) begin
                  state <= STALL;
                  cnt   <= CNT_INIT;
               end
            end
            STALL: begin
               if (cnt == 3'd0) state <= IDLE;
               else             cnt   <= cnt - 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Hit is only acted on from IDLE; in STALL the stall is already running.
   assign stall  = !rst && !flush && ((state == STALL) || hit);
   assign bubble = stall;
   assign busy   = !rst && (state == STALL);

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (LOAD_STALL = 1, 3, 4) share one
// stimulus stream; a cycle-level reference model tracks remaining stall
// cycles per instance and the forwarding rule.
module tb_hazard_unit;

   localparam int AW = 5;
`ifdef HAZARD_WB_FWD_EN
   localparam bit WB_ON = 1'b1;
`else
   localparam bit WB_ON = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] ID_rs = '0, ID_rt = '0, ID_EX_rs = '0, ID_EX_rt = '0;
   logic [AW-1:0] ID_EX_rd = '0, EX_M_rd = '0, M_WB_rd = '0;
   logic          ID_useRs = 1'b0, ID_useRt = 1'b0, ID_EX_memRead = 1'b0;
   logic          EX_M_regWrite = 1'b0, M_WB_regWrite = 1'b0, flush = 1'b0;

   logic [1:0] fa [3];
   logic [1:0] fb [3];
   logic       st [3];
   logic       bb [3];
   logic       bz [3];

   hazard_unit #(.REG_AW(AW), .LOAD_STALL(1)) u_ls1 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_useRs(ID_useRs),
      .ID_useRt(ID_useRt), .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt),
      .ID_EX_memRead(ID_EX_memRead), .ID_EX_rd(ID_EX_rd),
      .EX_M_regWrite(EX_M_regWrite), .EX_M_rd(EX_M_rd),
      .M_WB_regWrite(M_WB_regWrite), .M_WB_rd(M_WB_rd), .flush(flush),
      .forwardA(fa[0]), .forwardB(fb[0]), .stall(st[0]), .bubble(bb[0]), .busy(bz[0]));

   hazard_unit #(.REG_AW(AW), .LOAD_STALL(3)) u_ls3 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_useRs(ID_useRs),
      .ID_useRt(ID_useRt), .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt),
      .ID_EX_memRead(ID_EX_memRead), .ID_EX_rd(ID_EX_rd),
      .EX_M_regWrite(EX_M_regWrite), .EX_M_rd(EX_M_rd),
      .M_WB_regWrite(M_WB_regWrite), .M_WB_rd(M_WB_rd), .flush(flush),
      .forwardA(fa[1]), .forwardB(fb[1]), .stall(st[1]), .bubble(bb[1]), .busy(bz[1]));

   hazard_unit #(.REG_AW(AW), .LOAD_STALL(4)) u_ls4 (
      .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_useRs(ID_useRs),
      .ID_useRt(ID_useRt), .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt),
      .ID_EX_memRead(ID_EX_memRead), .ID_EX_rd(ID_EX_rd),
      .EX_M_regWrite(EX_M_regWrite), .EX_M_rd(EX_M_rd),
      .M_WB_regWrite(M_WB_regWrite), .M_WB_rd(M_WB_rd), .flush(flush),
      .forwardA(fa[2]), .forwardB(fb[2]), .stall(st[2]), .bubble(bb[2]), .busy(bz[2]));

   // ---------------- scoreboard / reference model ----------------
   int errors = 0;
   int checks = 0;
   int ls  [3] = '{1, 3, 4};
   int rem [3] = '{0, 0, 0};   // stall cycles still owed after the current one

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
      if (EX_M_regWrite && EX_M_rd != 0 && EX_M_rd == src) return 2'b01;
      if (WB_ON && M_WB_regWrite && M_WB_rd != 0 && M_WB_rd == src) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit ref_hit();
      return ID_EX_memRead && ID_EX_rd != 0 &&
             ((ID_useRs && ID_EX_rd == ID_rs) || (ID_useRt && ID_EX_rd == ID_rt));
   endfunction

   // One pipeline cycle: compare at negedge against the model (and optionally
   // against hand-written values ev = {busy1,stall1,busy3,stall3,busy4,stall4}),
   // then advance the model across the rising edge.
   task automatic step(input bit use_exp, input logic [5:0] ev, input string tag);
      bit h, es, eb;
      logic [1:0] efa, efb;
      @(negedge clk);
      h   = ref_hit();
      efa = rst ? 2'b00 : ref_fwd(ID_EX_rs);
      efb = rst ? 2'b00 : ref_fwd(ID_EX_rt);
      for (int k = 0; k < 3; k++) begin
         if (rst)            begin es = 0; eb = 0; end
         else if (flush)     begin es = 0; eb = (rem[k] > 0); end
         else if (rem[k] > 0) begin es = 1; eb = 1; end
         else                begin es = h; eb = 0; end
         chk($sformatf("%s fwdA ls%0d", tag, ls[k]), 8'(fa[k]), 8'(efa));
         chk($sformatf("%s fwdB ls%0d", tag, ls[k]), 8'(fb[k]), 8'(efb));
         chk($sformatf("%s stall ls%0d", tag, ls[k]), 8'(st[k]), 8'(es));
         chk($sformatf("%s bubble ls%0d", tag, ls[k]), 8'(bb[k]), 8'(es));
         chk($sformatf("%s busy ls%0d", tag, ls[k]), 8'(bz[k]), 8'(eb));
         if (use_exp) begin
            chk($sformatf("%s seq_stall ls%0d", tag, ls[k]), 8'(st[k]), 8'(ev[2*(2-k)]));
            chk($sformatf("%s seq_busy ls%0d", tag, ls[k]), 8'(bz[k]), 8'(ev[2*(2-k)+1]));
         end
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (rst || flush)    rem[k] = 0;
         else if (rem[k] > 0) rem[k] = rem[k] - 1;
         else if (h)          rem[k] = ls[k] - 1;
      end
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_load(input bit mem, input bit use_rt, input bit fl);
      ID_EX_memRead = mem;
      ID_EX_rd      = 5'd9;
      ID_rt         = 5'd9;
      ID_rs         = 5'd2;
      ID_useRt      = use_rt;
      ID_useRs      = 1'b1;
      flush         = fl;
   endtask

   typedef struct {
      logic          ex_we;
      logic [AW-1:0] ex_rd;
      logic          wb_we;
      logic [AW-1:0] wb_rd;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [1:0]    fa;
      logic [1:0]    fb;
   } fwd_vec_t;

   fwd_vec_t vecs [8];

   initial begin
      logic [1:0] xa, xb;
      vecs[0] = '{1'b1, 5'd8,  1'b1, 5'd8,  5'd8,  5'd3, 2'b01, 2'b00};
      vecs[1] = '{1'b0, 5'd8,  1'b1, 5'd8,  5'd8,  5'd8, 2'b10, 2'b10};
      vecs[2] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0, 2'b00, 2'b00};
      vecs[3] = '{1'b1, 5'd5,  1'b1, 5'd7,  5'd7,  5'd5, 2'b10, 2'b01};
      vecs[4] = '{1'b0, 5'd5,  1'b0, 5'd7,  5'd5,  5'd7, 2'b00, 2'b00};
      vecs[5] = '{1'b1, 5'd31, 1'b0, 5'd31, 5'd31, 5'd2, 2'b01, 2'b00};
      vecs[6] = '{1'b1, 5'd4,  1'b1, 5'd0,  5'd0,  5'd4, 2'b00, 2'b01};
      vecs[7] = '{1'b1, 5'd6,  1'b1, 5'd6,  5'd2,  5'd6, 2'b00, 2'b01};

      // Reset with forwardable fields and a live hit: everything must read 0.
      EX_M_regWrite = 1'b1; EX_M_rd = 5'd8; ID_EX_rs = 5'd8; ID_EX_rt = 5'd8;
      drive_load(1'b1, 1'b1, 1'b0);
      step(1'b1, 6'b000000, "reset0");
      step(1'b1, 6'b000000, "reset1");
      rst = 1'b0;
      drive_load(1'b0, 1'b0, 1'b0);

      // Forwarding table.
      for (int i = 0; i < 8; i++) begin
         EX_M_regWrite = vecs[i].ex_we; EX_M_rd = vecs[i].ex_rd;
         M_WB_regWrite = vecs[i].wb_we; M_WB_rd = vecs[i].wb_rd;
         ID_EX_rs = vecs[i].rs; ID_EX_rt = vecs[i].rt;
         xa = vecs[i].fa; xb = vecs[i].fb;
         if (!WB_ON && xa == 2'b10) xa = 2'b00;
         if (!WB_ON && xb == 2'b10) xb = 2'b00;
         #2;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("vec%0d fwdA ls%0d", i, ls[k]), 8'(fa[k]), 8'(xa));
            chk($sformatf("vec%0d fwdB ls%0d", i, ls[k]), 8'(fb[k]), 8'(xb));
         end
         step(1'b1, 6'b000000, $sformatf("vec%0d", i));
      end

      // Single load-use pulse, then the same load without the rt use.
      drive_load(1'b1, 1'b1, 1'b0); step(1'b1, 6'b010101, "pulse1");
      drive_load(1'b0, 1'b0, 1'b0); step(1'b1, 6'b001111, "pulse2");
      step(1'b1, 6'b001111, "pulse3");
      step(1'b1, 6'b000011, "pulse4");
      step(1'b1, 6'b000000, "pulse5");
      drive_load(1'b1, 1'b0, 1'b0); step(1'b1, 6'b000000, "nouse");
      drive_load(1'b0, 1'b0, 1'b0); step(1'b1, 6'b000000, "nouse2");

      // Flush on stall cycle 2.
      drive_load(1'b1, 1'b1, 1'b0); step(1'b1, 6'b010101, "fl_hit");
      drive_load(1'b0, 1'b0, 1'b1); step(1'b1, 6'b001010, "fl_mid");
      drive_load(1'b0, 1'b0, 1'b0); step(1'b1, 6'b000000, "fl_after");

      // Hit and flush in the same cycle.
      drive_load(1'b1, 1'b1, 1'b1); step(1'b1, 6'b000000, "hitfl");
      drive_load(1'b0, 1'b0, 1'b0); step(1'b1, 6'b000000, "hitfl2");
      step(1'b1, 6'b000000, "hitfl3");

      // Reset on stall cycle 2.
      drive_load(1'b1, 1'b1, 1'b0); step(1'b1, 6'b010101, "rs_hit");
      drive_load(1'b0, 1'b0, 1'b0); rst = 1'b1; step(1'b1, 6'b000000, "rs_mid");
      rst = 1'b0; step(1'b1, 6'b000000, "rs_after");
      step(1'b1, 6'b000000, "rs_after2");

      // Back-to-back loads: hit held for 10 cycles, model tracks restarts.
      drive_load(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 6'b0, "b2b");
      drive_load(1'b0, 1'b0, 1'b0);

      // Randomized stimulus against the model.
      for (int i = 0; i < 500; i++) begin
         rst           = ($urandom_range(0, 49) == 0);
         flush         = ($urandom_range(0, 7) == 0);
         ID_rs         = 5'($urandom_range(0, 3));
         ID_rt         = 5'($urandom_range(0, 3));
         ID_useRs      = 1'($urandom_range(0, 1));
         ID_useRt      = 1'($urandom_range(0, 1));
         ID_EX_rs      = 5'($urandom_range(0, 3));
         ID_EX_rt      = 5'($urandom_range(0, 3));
         ID_EX_memRead = ($urandom_range(0, 2) != 0);
         ID_EX_rd      = 5'($urandom_range(0, 3));
         EX_M_regWrite = 1'($urandom_range(0, 1));
         EX_M_rd       = 5'($urandom_range(0, 3));
         M_WB_regWrite = 1'($urandom_range(0, 1));
         M_WB_rd       = 5'($urandom_range(0, 3));
         step(1'b0, 6'b0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
